// File: rtl/core_run_ctrl.sv
// Run controller for the accumulator core: sequences reset/run/done for each
// program run, enforces a cycle timeout and arbitrates the dmem port between host and core.
module core_run_ctrl #(
  parameter int unsigned    AW         = 8,
  parameter int unsigned    DW         = 8,
  parameter int unsigned    CW         = 16,
  parameter int unsigned    RST_CYCLES = 2,
  parameter logic [CW-1:0]  TIMEOUT    = 16'd50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_done,
  output logic          core_reset,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_di,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic          host_err,
  output logic [CW-1:0] cycle_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RST  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int unsigned    RCW          = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST     = RCW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]  TIMEOUT_LAST = TIMEOUT - 1'b1;

  logic [1:0]     state_q, state_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]  cycle_count_q, cycle_count_d;
  logic           timeout_q, timeout_d;
  logic           host_err_q, host_err_d;

  // NOTE: every _d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    host_err_d    = host_we && ((state_q == S_RST) || (state_q == S_RUN));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_RST;
          rst_cnt_d     = '0;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // The cycle that sees core_done still counts; done beats a coincident timeout.
        cycle_count_d = cycle_count_q + 1'b1;
        if (core_done) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (cycle_count_q == TIMEOUT_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      host_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      host_err_q    <= host_err_d;
    end
  end

  assign core_reset  = (state_q != S_RUN);
  assign busy        = (state_q == S_RST) || (state_q == S_RUN);
  assign finished    = (state_q == S_DONE);
  assign timeout     = timeout_q;
  assign host_err    = host_err_q;
  assign cycle_count = cycle_count_q;

  // While the core is held in reset nobody may write; the address still tracks the host.
  always_comb begin
    mem_we   = host_we;
    mem_addr = host_addr;
    mem_di   = host_wdata;
    case (state_q)
      S_RUN: begin
        mem_we   = core_we;
        mem_addr = core_addr;
        mem_di   = core_wdata;
      end
      S_RST:   mem_we = 1'b0;
      default: mem_we = host_we;
    endcase
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural run model.
module tb_core_run_ctrl;

  localparam int unsigned   AW         = 8;
  localparam int unsigned   DW         = 8;
  localparam int unsigned   CW         = 16;
  localparam int unsigned   RST_CYCLES = 2;
  localparam logic [CW-1:0] TIMEOUT    = 16'd20;

  logic          clk = 1'b0;
  logic          reset, start, host_we, core_we, core_done;
  logic [AW-1:0] host_addr, core_addr, mem_addr;
  logic [DW-1:0] host_wdata, core_wdata, mem_di;
  logic          core_reset, mem_we, busy, finished, timeout, host_err;
  logic [CW-1:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  core_run_ctrl #(
    .AW(AW), .DW(DW), .CW(CW), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_done(core_done), .core_reset(core_reset),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .busy(busy), .finished(finished), .timeout(timeout),
    .host_err(host_err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what phase of a run we are in, how many reset cycles remain,
  // how many run cycles have elapsed, and whether the last run ran out of time.
  typedef enum {M_IDLE, M_HOLD, M_RUN, M_DONE} mphase_t;
  mphase_t     m_ph   = M_IDLE;
  int          m_hold = 0;
  int          m_cnt  = 0;
  bit          m_to   = 1'b0;
  bit          m_herr = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_ph = M_IDLE; m_hold = 0; m_cnt = 0; m_to = 1'b0; m_herr = 1'b0;
    end else begin
      m_herr = host_we && (m_ph == M_HOLD || m_ph == M_RUN);
      case (m_ph)
        M_IDLE, M_DONE:
          if (start) begin
            m_ph = M_HOLD; m_hold = RST_CYCLES; m_cnt = 0; m_to = 1'b0;
          end
        M_HOLD: begin
          m_hold = m_hold - 1;
          if (m_hold == 0) m_ph = M_RUN;
        end
        M_RUN: begin
          m_cnt = m_cnt + 1;
          if (core_done) begin
            m_ph = M_DONE; m_to = 1'b0;
          end else if (m_cnt == int'(TIMEOUT)) begin
            m_ph = M_DONE; m_to = 1'b1;
          end
        end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("core_reset",  32'(core_reset),  32'(m_ph != M_RUN));
      check("busy",        32'(busy),        32'(m_ph == M_HOLD || m_ph == M_RUN));
      check("finished",    32'(finished),    32'(m_ph == M_DONE));
      check("timeout",     32'(timeout),     32'(m_to));
      check("host_err",    32'(host_err),    32'(m_herr));
      check("cycle_count", 32'(cycle_count), 32'(m_cnt));
      if (m_ph == M_RUN) begin
        check("mem_we",   32'(mem_we),   32'(core_we));
        check("mem_addr", 32'(mem_addr), 32'(core_addr));
        check("mem_di",   32'(mem_di),   32'(core_wdata));
      end else begin
        check("mem_we",   32'(mem_we),   32'(host_we && m_ph != M_HOLD));
        check("mem_addr", 32'(mem_addr), 32'(host_addr));
        check("mem_di",   32'(mem_di),   32'(host_wdata));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; host_we = 1'b0; core_we = 1'b0; core_done = 1'b0;
    host_addr = '0; host_wdata = '0; core_addr = '0; core_wdata = '0;

    step();
    cmp_en = 1'b1;
    check("rst core_reset", 32'(core_reset), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst finished", 32'(finished), 32'd0);
    check("rst timeout", 32'(timeout), 32'd0);
    check("rst host_err", 32'(host_err), 32'd0);
    check("rst cycle_count", 32'(cycle_count), 32'd0);
    step();
    reset = 1'b0;

    // Host write while idle goes straight through
    host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A;
    #1;
    check("idle mem_we", 32'(mem_we), 32'd1);
    check("idle mem_addr", 32'(mem_addr), 32'h10);
    check("idle mem_di", 32'(mem_di), 32'h5A);
    check("idle busy", 32'(busy), 32'd0);
    step();
    host_we = 1'b0;
    check("idle no host_err", 32'(host_err), 32'd0);

    // Run A: start at T, done at T+12
    pulse_start();                                        // T+1
    check("T+1 core_reset", 32'(core_reset), 32'd1);
    check("T+1 busy", 32'(busy), 32'd1);
    host_we = 1'b1; host_addr = 8'h55; host_wdata = 8'hAA;
    #1;
    check("rst mem_we blocked", 32'(mem_we), 32'd0);
    check("rst mem_addr host", 32'(mem_addr), 32'h55);
    step();                                               // T+2
    host_we = 1'b0;
    check("T+2 core_reset", 32'(core_reset), 32'd1);
    check("rst host_err", 32'(host_err), 32'd1);
    step();                                               // T+3
    check("T+3 core_reset", 32'(core_reset), 32'd0);
    check("T+3 host_err clear", 32'(host_err), 32'd0);
    core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h33;
    host_we = 1'b1; host_addr = 8'h44; host_wdata = 8'h99;
    #1;
    check("run mem_we", 32'(mem_we), 32'd1);
    check("run mem_addr", 32'(mem_addr), 32'h20);
    check("run mem_di", 32'(mem_di), 32'h33);
    step();                                               // T+4
    host_we = 1'b0; core_we = 1'b0;
    check("run host_err", 32'(host_err), 32'd1);
    step();                                               // T+5
    check("run host_err one cycle", 32'(host_err), 32'd0);
    pulse_start();                                        // T+6, ignored
    check("start in run busy", 32'(busy), 32'd1);
    check("start in run core_reset", 32'(core_reset), 32'd0);
    step_n(6);                                            // T+12
    core_done = 1'b1;
    step();                                               // T+13
    core_done = 1'b0;
    check("A finished", 32'(finished), 32'd1);
    check("A cycle_count", 32'(cycle_count), 32'd10);
    check("A timeout", 32'(timeout), 32'd0);

    // Run B from DONE: runs out of time
    pulse_start();
    check("B finished clr", 32'(finished), 32'd0);
    check("B cycle_count clr", 32'(cycle_count), 32'd0);
    step_n(22);
    check("B finished", 32'(finished), 32'd1);
    check("B timeout", 32'(timeout), 32'd1);
    check("B cycle_count", 32'(cycle_count), 32'(TIMEOUT));

    // Run C: done on the same cycle the timeout would fire
    pulse_start();
    check("C timeout clr", 32'(timeout), 32'd0);
    step_n(21);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("C finished", 32'(finished), 32'd1);
    check("C timeout", 32'(timeout), 32'd0);
    check("C cycle_count", 32'(cycle_count), 32'd20);

    // Run D: reset on the 5th run cycle
    pulse_start();
    step_n(6);
    check("D running", 32'(core_reset), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("D core_reset", 32'(core_reset), 32'd1);
    check("D busy", 32'(busy), 32'd0);
    check("D cycle_count", 32'(cycle_count), 32'd0);
    core_we = 1'b1; core_addr = 8'h20;
    host_we = 1'b1; host_addr = 8'h77; host_wdata = 8'h11;
    #1;
    check("D mem_we host", 32'(mem_we), 32'd1);
    check("D mem_addr host", 32'(mem_addr), 32'h77);
    host_we = 1'b0;
    #1;
    check("D core_we dropped", 32'(mem_we), 32'd0);
    core_we = 1'b0;
    step();

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 15) == 0);
      host_we    = ($urandom_range(0, 3) == 0);
      core_we    = ($urandom_range(0, 1) == 0);
      core_done  = ($urandom_range(0, 29) == 0);
      host_addr  = AW'($urandom);
      host_wdata = DW'($urandom);
      core_addr  = AW'($urandom);
      core_wdata = DW'($urandom);
      step();
    end
    reset = 1'b0; start = 1'b0; host_we = 1'b0; core_we = 1'b0; core_done = 1'b0;
    step_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
